// File: rtl/riscv_rb_ctrl.sv
// Access controller for the 32x32 RISC-V register bank: shares the write port and rs1 read
// port between the core, a four-phase host debug port and a sequenced clear of x1..x31.
module riscv_rb_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    // core side
    input  logic        core_ce,
    input  logic        core_rwr,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_wbdat,
    input  logic        core_rs_valid,
    input  logic [4:0]  core_rs1,
    input  logic [4:0]  core_rs2,
    output logic [31:0] core_rs1d,
    output logic [31:0] core_rs2d,
    output logic        core_stall,
    // bank side
    output logic        rb_ce,
    output logic        rb_rwr,
    output logic [4:0]  rb_rd,
    output logic [31:0] rb_wbdat,
    output logic [4:0]  rb_rs1,
    output logic [4:0]  rb_rs2,
    input  logic [31:0] rb_rs1d,
    input  logic [31:0] rb_rs2d,
    // host debug port
    input  logic        host_req,
    input  logic        host_we,
    input  logic [4:0]  host_addr,
    input  logic [31:0] host_wdat,
    output logic        host_ack,
    output logic [31:0] host_rdat,
    // clear sequencer
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        clr_done
);

    typedef enum logic [1:0] {IDLE, HWAIT, HACK, CLEAR} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [4:0]        clr_idx;
    logic              h_we;
    logic [4:0]        h_addr;
    logic [31:0]       h_wdat;

    logic core_busy;
    logic at_limit;
    logic host_slot;
    logic steal;

    // The core only contends when it is using the very port the host access needs.
    assign core_busy = h_we ? (core_ce & core_rwr) : core_rs_valid;
    assign at_limit  = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign host_slot = (state == HWAIT) && (!core_busy || at_limit);
    assign steal     = (state == HWAIT) && core_busy && at_limit;

    assign core_stall = clr_busy | steal;
    assign core_rs1d  = rb_rs1d;
    assign core_rs2d  = rb_rs2d;

    always_comb begin
        // NOTE: every output gets its pass-through value first so no path leaves it unassigned (no latch).
        rb_ce    = core_ce;
        rb_rwr   = core_rwr;
        rb_rd    = core_rd;
        rb_wbdat = core_wbdat;
        rb_rs1   = core_rs1;
        rb_rs2   = core_rs2;
        if (state == CLEAR) begin
            rb_ce    = 1'b1;
            rb_rwr   = 1'b1;
            rb_rd    = clr_idx;
            rb_wbdat = '0;
        end else if (host_slot) begin
            if (h_we) begin
                rb_ce    = 1'b1;
                rb_rwr   = 1'b1;
                rb_rd    = h_addr;
                rb_wbdat = h_wdat;
            end else begin
                rb_rs1 = h_addr;
            end
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            clr_idx   <= 5'd1;
            h_we      <= 1'b0;
            h_addr    <= '0;
            h_wdat    <= '0;
            host_ack  <= 1'b0;
            host_rdat <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        clr_busy <= 1'b1;
                        state    <= CLEAR;
                    end else if (host_req) begin
                        h_we     <= host_we;
                        h_addr   <= host_addr;
                        h_wdat   <= host_wdat;
                        wait_cnt <= '0;
                        state    <= HWAIT;
                    end
                end
                HWAIT: begin
                    if (host_slot) begin
                        host_rdat <= h_we ? h_wdat : rb_rs1d;
                        host_ack  <= 1'b1;
                        state     <= HACK;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HACK: begin
                    if (!host_req) begin
                        host_ack <= 1'b0;
                        state    <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_idx == 5'd31) begin
                        clr_idx  <= 5'd1;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        clr_idx <= clr_idx + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_rb_ctrl.sv
// Self-checking bench for riscv_rb_ctrl with a behavioural register bank attached to its rb_* side.
module tb_riscv_rb_ctrl;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_ce, core_rwr, core_rs_valid;
    logic [4:0]  core_rd, core_rs1, core_rs2;
    logic [31:0] core_wbdat, core_rs1d, core_rs2d;
    logic        core_stall;
    logic        rb_ce, rb_rwr;
    logic [4:0]  rb_rd, rb_rs1, rb_rs2;
    logic [31:0] rb_wbdat, rb_rs1d, rb_rs2d;
    logic        host_req, host_we, host_ack;
    logic [4:0]  host_addr;
    logic [31:0] host_wdat, host_rdat;
    logic        clr_req, clr_busy, clr_done;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_rb_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .clk(clk), .rst(rst),
        .core_ce(core_ce), .core_rwr(core_rwr), .core_rd(core_rd), .core_wbdat(core_wbdat),
        .core_rs_valid(core_rs_valid), .core_rs1(core_rs1), .core_rs2(core_rs2),
        .core_rs1d(core_rs1d), .core_rs2d(core_rs2d), .core_stall(core_stall),
        .rb_ce(rb_ce), .rb_rwr(rb_rwr), .rb_rd(rb_rd), .rb_wbdat(rb_wbdat),
        .rb_rs1(rb_rs1), .rb_rs2(rb_rs2), .rb_rs1d(rb_rs1d), .rb_rs2d(rb_rs2d),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
        .host_ack(host_ack), .host_rdat(host_rdat),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Register bank: combinational reads, x0 reads zero, write on edge gated by ce.
    logic [31:0] bank [32];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) bank[i] <= '0;
        end else if (rb_ce && rb_rwr && rb_rd != 5'd0) begin
            bank[rb_rd] <= rb_wbdat;
        end
    end
    assign rb_rs1d = (rb_rs1 == 5'd0) ? 32'h0 : bank[rb_rs1];
    assign rb_rs2d = (rb_rs2 == 5'd0) ? 32'h0 : bank[rb_rs2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four-phase host access started in an IDLE cycle; returns cycles from request to ack.
    task automatic host_access(input logic we, input logic [4:0] addr, input logic [31:0] wdat,
                               output logic [31:0] rdat, output int lat, output bit ok);
        host_req  = 1'b1;
        host_we   = we;
        host_addr = addr;
        host_wdat = wdat;
        ok  = 1'b0;
        lat = -1;
        rdat = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_ack) begin
                ok   = 1'b1;
                lat  = i;
                rdat = host_rdat;
                break;
            end
            tick();
        end
        if (!ok) check("host ack timeout", 32'd0, 32'd1);
        tick();
        host_req = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        logic        ce, rwr;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        rsv;
        logic [4:0]  rs1, rs2;
        logic [31:0] exp_rs1d, exp_rs2d;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] mdl [32];
    logic [31:0] rdat, held;
    int          lat, stalls, stall_at, ack_at, done_at, first_busy;
    int          busy_cnt, done_cnt, bad_stall, bad_idx, early_ack, bad;
    bit          ok, core_done;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 5'd4, 32'h1234_5678, 1'b1, 5'd3, 5'd4, 32'hA5A5_A5A5, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd4, 5'd5, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 5'd6, 32'h0, 1'b1, 5'd5, 5'd3, 32'h0, 32'hA5A5_A5A5};
        vecs[4] = '{1'b1, 1'b1, 5'd0, 32'hDEAD_0000, 1'b1, 5'd0, 5'd31, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4, 32'h0, 32'h1234_5678};

        rst = 1'b0;
        {core_ce, core_rwr, core_rs_valid, host_req, host_we, clr_req} = '0;
        core_rd = '0; core_rs1 = '0; core_rs2 = '0; core_wbdat = '0;
        host_addr = '0; host_wdat = '0;

        // ---- reset values ----
        tick(); tick();
        @(negedge clk);
        check("reset host_ack", host_ack, 0);
        check("reset host_rdat", host_rdat, 0);
        check("reset core_stall", core_stall, 0);
        check("reset clr_busy", clr_busy, 0);
        check("reset clr_done", clr_done, 0);
        tick();
        rst = 1'b1;
        tick();

        // ---- table-driven core pass-through ----
        for (int i = 0; i < 6; i++) begin
            core_ce = vecs[i].ce;   core_rwr = vecs[i].rwr; core_rd = vecs[i].rd;
            core_wbdat = vecs[i].wb; core_rs_valid = vecs[i].rsv;
            core_rs1 = vecs[i].rs1; core_rs2 = vecs[i].rs2;
            @(negedge clk);
            check($sformatf("vec%0d rb_ce", i), rb_ce, vecs[i].ce);
            check($sformatf("vec%0d rb_rwr", i), rb_rwr, vecs[i].rwr);
            check($sformatf("vec%0d rb_rd", i), rb_rd, vecs[i].rd);
            check($sformatf("vec%0d rb_wbdat", i), rb_wbdat, vecs[i].wb);
            check($sformatf("vec%0d rb_rs1", i), rb_rs1, vecs[i].rs1);
            check($sformatf("vec%0d rb_rs2", i), rb_rs2, vecs[i].rs2);
            check($sformatf("vec%0d stall", i), core_stall, 0);
            check($sformatf("vec%0d rs1d", i), core_rs1d, vecs[i].exp_rs1d);
            check($sformatf("vec%0d rs2d", i), core_rs2d, vecs[i].exp_rs2d);
            tick();
        end
        {core_ce, core_rwr, core_rs_valid} = '0;
        tick();

        // ---- host write with idle core, then read back ----
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd5; host_wdat = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t2 c0 ack", host_ack, 0);
        check("t2 c0 rwr", rb_rwr, 0);
        tick();
        @(negedge clk);
        check("t2 c1 rb_rwr", rb_rwr, 1);
        check("t2 c1 rb_ce", rb_ce, 1);
        check("t2 c1 rb_rd", rb_rd, 5);
        check("t2 c1 rb_wbdat", rb_wbdat, 32'hDEAD_BEEF);
        check("t2 c1 ack", host_ack, 0);
        tick();
        @(negedge clk);
        check("t2 c2 ack", host_ack, 1);
        check("t2 c2 rdat echo", host_rdat, 32'hDEAD_BEEF);
        tick();
        host_req = 1'b0;
        tick(); tick();
        host_access(1'b0, 5'd5, 32'h0, rdat, lat, ok);
        check("t2 read x5", rdat, 32'hDEAD_BEEF);
        check("t2 read latency", lat, 2);

        // ---- host write against continuous core writes: steal ----
        core_ce = 1'b1; core_rwr = 1'b1; core_rd = 5'd10; core_wbdat = 32'h1000_0000;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd7; host_wdat = 32'hCAFE_0007;
        stalls = 0; stall_at = -1; ack_at = -1; held = '0;
        for (int c = 0; c < 30 && ack_at < 0; c++) begin
            bit st;
            @(negedge clk);
            st = core_stall;
            if (st) begin
                stalls++;
                stall_at = c;
                held = core_wbdat;
                check("t3 steal rb_rd", rb_rd, 7);
                check("t3 steal rb_wbdat", rb_wbdat, 32'hCAFE_0007);
            end else if (stall_at >= 0 && c == stall_at + 1) begin
                check("t3 retry rb_rd", rb_rd, 10);
                check("t3 retry rb_wbdat", rb_wbdat, held);
            end
            if (host_ack) ack_at = c;
            tick();
            if (!st) core_wbdat = core_wbdat + 1;
        end
        check("t3 stall count", stalls, 1);
        check("t3 stall cycle", stall_at, MAX_WAIT);
        check("t3 ack cycle", ack_at, MAX_WAIT + 1);
        check("t3 x7", bank[7], 32'hCAFE_0007);
        check("t3 x10 retried write", bank[10], held);
        host_req = 1'b0; core_ce = 1'b0; core_rwr = 1'b0;
        tick(); tick();

        // ---- host read against continuous core reads: steal ----
        core_rs_valid = 1'b1; core_rs1 = 5'd1; core_rs2 = 5'd2;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd3;
        stalls = 0; stall_at = -1; ack_at = -1;
        for (int c = 0; c < 30 && ack_at < 0; c++) begin
            @(negedge clk);
            if (core_stall) begin
                stalls++;
                stall_at = c;
                check("t4 steal rb_rs1", rb_rs1, 3);
                check("t4 steal rb_rs2", rb_rs2, 2);
            end
            if (host_ack) ack_at = c;
            tick();
        end
        check("t4 stall count", stalls, 1);
        check("t4 stall cycle", stall_at, MAX_WAIT);
        check("t4 host_rdat x3", host_rdat, 32'hA5A5_A5A5);
        host_req = 1'b0; core_rs_valid = 1'b0;
        tick(); tick();

        // ---- preload, clear, host read raised mid-clear ----
        core_ce = 1'b1; core_rwr = 1'b1;
        for (int i = 1; i < 32; i++) begin
            core_rd = 5'(i);
            core_wbdat = 32'h0101_0101 * 32'(i);
            tick();
        end
        core_ce = 1'b0; core_rwr = 1'b0;
        check("t5 preload x17", bank[17], 32'h1111_1111);
        clr_req = 1'b1;
        busy_cnt = 0; done_cnt = 0; bad_stall = 0; bad_idx = 0; done_at = -1; ack_at = -1; early_ack = 0;
        for (int c = 0; c < 60 && ack_at < 0; c++) begin
            @(negedge clk);
            if (clr_busy) begin
                busy_cnt++;
                if (!core_stall) bad_stall++;
                if (rb_rd != 5'(busy_cnt) || rb_wbdat != 32'h0 || !rb_rwr || !rb_ce) bad_idx++;
            end
            if (clr_done) begin
                done_cnt++;
                done_at = c;
                if (core_stall || clr_busy) bad_stall++;
            end
            if (host_ack) begin
                ack_at = c;
                if (done_at < 0) early_ack++;
            end
            tick();
            clr_req = 1'b0;
            if (c == 4) begin host_req = 1'b1; host_we = 1'b0; host_addr = 5'd4; end
        end
        check("t5 busy cycles", busy_cnt, 31);
        check("t5 done pulses", done_cnt, 1);
        check("t5 done cycle", done_at, 32);
        check("t5 stall during clear", bad_stall, 0);
        check("t5 clear index sequence", bad_idx, 0);
        check("t5 ack before done", early_ack, 0);
        check("t5 ack cycle", ack_at, 34);
        check("t5 host read x4", host_rdat, 0);
        host_req = 1'b0;
        tick(); tick();
        core_rs_valid = 1'b1;
        for (int i = 1; i < 32; i++) begin
            core_rs1 = 5'(i);
            core_rs2 = 5'(32 - i);
            @(negedge clk);
            check($sformatf("t5 cleared x%0d", i), core_rs1d, 0);
            tick();
        end
        core_rs_valid = 1'b0;

        // ---- clr_req and host_req together, then ack held ----
        clr_req = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd12; host_wdat = 32'h0C0C_0C0C;
        first_busy = -1; done_at = -1; ack_at = -1; early_ack = 0;
        for (int c = 0; c < 60 && ack_at < 0; c++) begin
            @(negedge clk);
            if (clr_busy && first_busy < 0) first_busy = c;
            if (clr_done) done_at = c;
            if (host_ack) begin
                ack_at = c;
                if (done_at < 0) early_ack++;
            end
            tick();
            clr_req = 1'b0;
        end
        check("t6 clear first", first_busy, 1);
        check("t6 done cycle", done_at, 32);
        check("t6 ack after clear", early_ack, 0);
        check("t6 ack cycle", ack_at, 34);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!host_ack || rb_rwr || rb_ce) bad++;
            tick();
        end
        check("t6 ack held, no second access", bad, 0);
        host_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("t6 ack released", host_ack, 0);
        check("t6 x12 after clear", bank[12], 32'h0C0C_0C0C);
        tick();

        // ---- reset in the middle of a pending host write ----
        core_ce = 1'b1; core_rwr = 1'b1; core_rd = 5'd9; core_wbdat = 32'h0000_0099;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd20; host_wdat = 32'h0000_0020;
        tick();
        tick();
        rst = 1'b0;
        tick();
        host_req = 1'b0;
        @(negedge clk);
        check("t1 host_ack", host_ack, 0);
        check("t1 host_rdat", host_rdat, 0);
        check("t1 core_stall", core_stall, 0);
        check("t1 clr_busy", clr_busy, 0);
        check("t1 clr_done", clr_done, 0);
        check("t1 rb_rwr follows core", rb_rwr, 1);
        check("t1 rb_rd follows core", rb_rd, 9);
        tick();
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (host_ack) bad++;
            tick();
        end
        check("t1 no ack after reset", bad, 0);
        check("t1 dropped write x20", bank[20], 0);
        check("t1 core write x9", bank[9], 32'h0000_0099);

        // ---- randomized traffic against a register-file model ----
        core_ce = 1'b0; core_rwr = 1'b0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        core_done = 1'b0;
        fork
            begin : core_side
                bit hold = 1'b0;
                for (int c = 0; c < 400; c++) begin
                    bit st;
                    if (!hold) begin
                        core_ce       = ($urandom_range(0, 3) != 0);
                        core_rwr      = 1'($urandom_range(0, 1));
                        core_rd       = 5'($urandom_range(1, 15));
                        core_wbdat    = $urandom;
                        core_rs_valid = 1'($urandom_range(0, 1));
                        core_rs1      = 5'($urandom_range(0, 15));
                        core_rs2      = 5'($urandom_range(0, 15));
                    end
                    @(negedge clk);
                    st = core_stall;
                    if (!st) begin
                        if (core_rs_valid) begin
                            check("rnd core rs1d", core_rs1d, mdl[core_rs1]);
                            check("rnd core rs2d", core_rs2d, mdl[core_rs2]);
                        end
                        if (core_ce && core_rwr) mdl[core_rd] = core_wbdat;
                    end
                    hold = st;
                    tick();
                end
                core_ce = 1'b0; core_rwr = 1'b0; core_rs_valid = 1'b0;
                core_done = 1'b1;
            end
            begin : host_side
                while (!core_done) begin
                    logic        we;
                    logic [4:0]  addr;
                    logic [31:0] wd;
                    repeat ($urandom_range(0, 3)) tick();
                    we   = 1'($urandom_range(0, 1));
                    addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
                    wd   = $urandom;
                    host_access(we, addr, wd, rdat, lat, ok);
                    if (ok) begin
                        check("rnd host latency bound", 32'(lat <= MAX_WAIT + 1), 1);
                        if (we) begin
                            check("rnd host write echo", rdat, wd);
                            if (addr != 5'd0) mdl[addr] = wd;
                        end else begin
                            check("rnd host read", rdat, mdl[addr]);
                        end
                    end
                end
            end
        join
        for (int i = 16; i < 32; i++) check($sformatf("rnd final x%0d", i), bank[i], mdl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
